// File: rtl/halflife_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : halflife_input_conditioner_if
// Purpose  : Pad-side buttons/switches and conditioned strobes for the
//            half-life timer input front end.
// Revision : 1.0 - initial release
// ============================================================================
interface halflife_input_conditioner_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [3:0] sw_in;
    logic       up_pulse;
    logic       down_pulse;
    logic       load_pulse;
    logic [3:0] value_out;

    modport master (
        output btn_up, btn_down, btn_load, sw_in,
        input  up_pulse, down_pulse, load_pulse, value_out
    );

    modport slave (
        input  btn_up, btn_down, btn_load, sw_in,
        output up_pulse, down_pulse, load_pulse, value_out
    );
endinterface
`default_nettype wire

// File: rtl/halflife_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : halflife_input_conditioner
// Purpose  : Synchronise and debounce raw buttons/switches; emit single-cycle
//            up/down/load strobes with up/down auto-repeat and a held setpoint.
// Revision : 1.0 - initial release
// ============================================================================
module halflife_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_RATE     = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    halflife_input_conditioner_if.slave   bus
);

    localparam int c_TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX);

    localparam logic [15:0]          c_DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_DELAY_LOAD = c_TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [c_TIMER_W-1:0] c_RATE_LOAD  = c_TIMER_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // Button bit order throughout: [0]=up, [1]=down, [2]=load
    logic [2:0] btn_raw;
    logic [2:0] btn_meta_q;
    logic [2:0] btn_sync_q;
    logic [3:0] sw_meta_q;
    logic [3:0] sw_sync_q;

    logic [2:0] stable_lvl;
    logic [2:0] stable_dly_q;
    logic [2:0] stable_rise;

    assign btn_raw = {bus.btn_load, bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.sw_in;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: level must disagree for DEBOUNCE_CYCLES edges
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 3; i++) begin : g_debounce
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;
            logic        stable_q;
            logic        stable_d;

            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (btn_sync_q[i] == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_DB_LAST) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_lvl[i] = stable_q;
        end
    endgenerate

    assign stable_rise = stable_lvl & ~stable_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_dly_q <= '0;
        end else begin
            stable_dly_q <= stable_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic       load_pulse_q;
    logic       load_pulse_d;
    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        load_pulse_d = stable_rise[2];
        value_d      = stable_rise[2] ? sw_sync_q : value_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pulse_q <= 1'b0;
            value_q      <= '0;
        end else begin
            load_pulse_q <= load_pulse_d;
            value_q      <= value_d;
        end
    end

    // ------------------------------------------------------------------
    // Up/down strobe and auto-repeat FSM
    // ------------------------------------------------------------------
    state_t                 state_q;
    state_t                 state_d;
    logic                   dir_q;      // 0 = up, 1 = down
    logic                   dir_d;
    logic [c_TIMER_W-1:0]   timer_q;
    logic [c_TIMER_W-1:0]   timer_d;
    logic                   up_pulse_q;
    logic                   up_pulse_d;
    logic                   down_pulse_q;
    logic                   down_pulse_d;
    logic                   held;

    assign held = dir_q ? stable_lvl[1] : stable_lvl[0];

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        timer_d      = timer_q;
        up_pulse_d   = 1'b0;
        down_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stable_rise[0] ^ stable_rise[1]) begin
                    up_pulse_d   = stable_rise[0];
                    down_pulse_d = stable_rise[1];
                    dir_d        = stable_rise[1];
                    timer_d      = c_DELAY_LOAD;
                    state_d      = ST_DELAY;
                end else if (stable_rise[0] && stable_rise[1]) begin
                    state_d = ST_LOCK;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // Release wins over an expiry landing on the same cycle
                if (!held) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    up_pulse_d   = ~dir_q;
                    down_pulse_d = dir_q;
                    timer_d      = c_RATE_LOAD;
                    state_d      = ST_REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCK: begin
                if (!stable_lvl[0] && !stable_lvl[1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            timer_q      <= '0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            up_pulse_q   <= up_pulse_d;
            down_pulse_q <= down_pulse_d;
        end
    end

    assign bus.up_pulse   = up_pulse_q;
    assign bus.down_pulse = down_pulse_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.value_out  = value_q;

endmodule
`default_nettype wire

// File: tb/tb_halflife_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_halflife_input_conditioner
// Purpose  : Self-checking bench: directed scenarios plus random button
//            activity compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_halflife_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst_n;

    halflife_input_conditioner_if bus ();

    halflife_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: stable level flips once the synchronised input has
    // disagreed with it for the last D edges; strobes are scheduled by
    // absolute edge number.
    // ------------------------------------------------------------------
    bit         m_p1 [3];
    bit         m_p2 [3];
    bit         m_st [3];
    bit         m_st_prev [3];
    bit [D-1:0] m_hist [3];
    bit         m_rise [3];
    bit [3:0]   m_sw1 = '0;
    bit [3:0]   m_sw2 = '0;
    int         m_mode = 0;     // 0 idle, 1 held, 2 locked
    int         m_next = 0;
    int         m_edge = 0;
    int         m_dir  = 0;
    bit         exp_up = 1'b0;
    bit         exp_down = 1'b0;
    bit         exp_load = 1'b0;
    bit [3:0]   exp_val = '0;
    logic [2:0] tb_raw;

    assign tb_raw = {bus.btn_load, bus.btn_down, bus.btn_up};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_st[i] = 1'b0;
                m_st_prev[i] = 1'b0; m_hist[i] = '0;
            end
            m_sw1 = '0; m_sw2 = '0;
            m_mode = 0; m_next = 0; m_edge = 0; m_dir = 0;
            exp_up = 1'b0; exp_down = 1'b0; exp_load = 1'b0; exp_val = '0;
        end else begin
            m_edge++;
            for (int i = 0; i < 3; i++) m_rise[i] = m_st[i] & ~m_st_prev[i];
            exp_up   = 1'b0;
            exp_down = 1'b0;
            exp_load = m_rise[2];
            if (m_rise[2]) exp_val = m_sw2;
            case (m_mode)
                0: begin
                    if (m_rise[0] != m_rise[1]) begin
                        m_dir    = m_rise[1] ? 1 : 0;
                        exp_up   = m_rise[0];
                        exp_down = m_rise[1];
                        m_next   = m_edge + RD;
                        m_mode   = 1;
                    end else if (m_rise[0]) begin
                        m_mode = 2;
                    end
                end
                1: begin
                    if (!m_st[m_dir]) begin
                        m_mode = 0;
                    end else if (m_edge == m_next) begin
                        exp_up   = (m_dir == 0);
                        exp_down = (m_dir == 1);
                        m_next   = m_edge + RR;
                    end
                end
                default: begin
                    if (!m_st[0] && !m_st[1]) m_mode = 0;
                end
            endcase
            for (int i = 0; i < 3; i++) begin
                m_hist[i]    = {m_hist[i][D-2:0], m_p2[i]};
                m_st_prev[i] = m_st[i];
                if (m_hist[i] == {D{~m_st[i]}}) m_st[i] = ~m_st[i];
                m_p2[i] = m_p1[i];
                m_p1[i] = tb_raw[i];
            end
            m_sw2 = m_sw1;
            m_sw1 = bus.sw_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_up",   32'(bus.up_pulse),   32'(exp_up));
            check("mdl_down", 32'(bus.down_pulse), 32'(exp_down));
            check("mdl_load", 32'(bus.load_pulse), 32'(exp_load));
            check("mdl_val",  32'(bus.value_out),  32'(exp_val));
        end
    end

    task automatic set_btn(input int which, input bit lvl);
        case (which)
            0:       bus.btn_up   = lvl;
            1:       bus.btn_down = lvl;
            default: bus.btn_load = lvl;
        endcase
    endtask

    // Press one button for `hold` edges and check strobe edges by formula
    task automatic press_check(input int which, input int hold, input int total);
        bit       rep;
        bit       e;
        bit [2:0] pulses;
        rep = (which != 2);
        @(negedge clk);
        set_btn(which, 1'b1);
        for (int k = 1; k <= total; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) set_btn(which, 1'b0);
            e = ((k == D + 3) && (hold >= D)) ||
                (rep && (k >= D + 3 + RD) && (k <= hold + D + 2) && ((k - D - 3 - RD) % RR == 0));
            pulses = {bus.load_pulse, bus.down_pulse, bus.up_pulse};
            for (int j = 0; j < 3; j++)
                check($sformatf("press%0d_pulse%0d_k%0d", which, j, k),
                      32'(pulses[j]), 32'((j == which) ? e : 1'b0));
            if (which == 2 && k == D + 3)
                check("load_value", 32'(bus.value_out), 32'(bus.sw_in));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int hold_left [3];

    initial begin
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_load = 1'b0; bus.sw_in = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_up",   32'(bus.up_pulse),   32'd0);
        check("rst_down", 32'(bus.down_pulse), 32'd0);
        check("rst_load", 32'(bus.load_pulse), 32'd0);
        check("rst_val",  32'(bus.value_out),  32'd0);
        rst_n = 1'b1;
        idle_cycles(4);

        // Clean press, then held press with auto-repeat
        press_check(0, 5, 20);
        idle_cycles(10);
        press_check(0, 40, 55);
        idle_cycles(10);
        press_check(1, 22, 35);
        idle_cycles(10);

        // Bounce rejection
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            bus.btn_down = (j % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bus.btn_down = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("bounce_down", 32'(bus.down_pulse), 32'd0);
        end

        // Load capture and hold
        bus.sw_in = 4'hA;
        press_check(2, 10, 20);
        check("load_held_a", 32'(bus.value_out), 32'hA);
        bus.sw_in = 4'h3;
        repeat (10) @(posedge clk);
        #1;
        check("load_no_recapture", 32'(bus.value_out), 32'hA);

        // Simultaneous up+down locks out strobes
        @(negedge clk);
        bus.btn_up = 1'b1; bus.btn_down = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 25) begin bus.btn_up = 1'b0; bus.btn_down = 1'b0; end
            check("lock_up",   32'(bus.up_pulse),   32'd0);
            check("lock_down", 32'(bus.down_pulse), 32'd0);
        end
        press_check(1, 5, 15);
        idle_cycles(10);

        // Reset mid-repeat with the button still held
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_up",   32'(bus.up_pulse),   32'd0);
        check("arst_down", 32'(bus.down_pulse), 32'd0);
        check("arst_load", 32'(bus.load_pulse), 32'd0);
        check("arst_val",  32'(bus.value_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("rel_up_k%0d", k), 32'(bus.up_pulse), 32'(k == D + 3));
        end
        bus.btn_up = 1'b0;
        idle_cycles(12);

        // Random button activity against the model
        for (int i = 0; i < 3; i++) hold_left[i] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] == 0) begin
                    set_btn(i, 1'($urandom_range(0, 1)));
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                               : int'($urandom_range(1, 6));
                end
                hold_left[i]--;
            end
            if ($urandom_range(0, 7) == 0) bus.sw_in = 4'($urandom_range(0, 15));
        end
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_load = 1'b0;
        idle_cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
